// File: rtl/weighted_sum_pipelined.sv
// Weighted (or plain) sum of N_CH unsigned channels: registered products, a pipelined
// adder tree, then a saturating output stage that can run an accumulation.
module weighted_sum_pipelined #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 13,
    parameter int WGT_W  = 13,
    parameter int OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rest,
    input  logic                     in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH*WGT_W-1:0]    in_weight,
    input  logic                     mode,
    input  logic                     acc_en,
    input  logic                     acc_clr,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         out_sum,
    output logic                     out_ovf
);

    localparam int LVL = $clog2(N_CH);
    localparam int PW  = DATA_W + WGT_W;
    localparam int SW  = PW + LVL;
    localparam int TW  = ((SW > OUT_W) ? SW : OUT_W) + 1;
    localparam logic [TW-1:0] SAT_MAX = (TW'(1) << OUT_W) - TW'(1);

    generate
        if ((N_CH < 2) || ((N_CH & (N_CH - 1)) != 0)) begin : g_bad_n_ch
            $error("weighted_sum_pipelined: N_CH must be a power of two >= 2");
        end
    endgenerate

    // Heap-ordered tree: leaves at [N_CH-1 .. 2*N_CH-2], root at [0]. Every node is a
    // register and all leaves sit at the same depth, so each level is one pipeline stage.
    // Nodes are carried at the root width; the unused upper bits are constant zero.
    logic [SW-1:0] node_q [2*N_CH-1];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_leaf
            logic [SW-1:0] d_ext;
            logic [SW-1:0] w_ext;
            assign d_ext = SW'(in_data[gi*DATA_W +: DATA_W]);
            assign w_ext = SW'(in_weight[gi*WGT_W +: WGT_W]);
            always_ff @(posedge clk) begin
                node_q[N_CH-1+gi] <= mode ? (d_ext * w_ext) : d_ext;
            end
        end
        for (gi = 0; gi < N_CH-1; gi++) begin : g_node
            always_ff @(posedge clk) begin
                node_q[gi] <= node_q[2*gi+1] + node_q[2*gi+2];
            end
        end
    endgenerate

    // Sideband travels with the data; index LVL lines up with the root register.
    logic [LVL:0]       vld_q;
    logic [LVL:0]       en_q;
    logic [LVL:0]       clr_q;
    logic               out_valid_q;
    logic [OUT_W-1:0]   sum_q;
    logic               ovf_q;

    logic               load;
    logic               sat;
    logic [TW-1:0]      t_d;
    logic [OUT_W-1:0]   sum_d;
    logic               ovf_d;

    always_ff @(posedge clk) begin
        en_q  <= {en_q[LVL-1:0], acc_en};
        clr_q <= {clr_q[LVL-1:0], acc_clr};
    end

    always_comb begin
        load  = clr_q[LVL] | ~en_q[LVL];
        t_d   = load ? TW'(node_q[0]) : (TW'(node_q[0]) + TW'(sum_q));
        sat   = (t_d > SAT_MAX);
        sum_d = sat ? {OUT_W{1'b1}} : t_d[OUT_W-1:0];
        ovf_d = load ? sat : (ovf_q | sat);
    end

    // sum_q doubles as the accumulator: both always hold the same saturated value.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            vld_q       <= {vld_q[LVL-1:0], in_valid};
            out_valid_q <= vld_q[LVL];
            if (vld_q[LVL]) begin
                sum_q <= sum_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_ovf   = ovf_q;

endmodule
